// File: rtl/reaction_round_ctrl_pkg.sv
// Shared encodings and helpers for the reaction game round sequencer.
package reaction_round_ctrl_pkg;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_ARM    = 3'd1,
        PH_WAIT   = 3'd2,
        PH_GO     = 3'd3,
        PH_RESULT = 3'd4,
        PH_FINISH = 3'd5
    } phase_e;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_HIT   = 2'd1,
        RES_EARLY = 2'd2,
        RES_MISS  = 2'd3
    } result_e;

    localparam logic [8:0] BEST_NONE = 9'h1FF;

    // Pre-go delay from a raw LFSR sample; short samples are pushed up by the minimum.
    function automatic logic [8:0] arm_delay(input logic [8:0] rand_val,
                                             input logic [8:0] min_delay);
        logic [8:0] v;
        v = (rand_val < min_delay) ? rand_val + min_delay : rand_val;
        return (v == '0) ? min_delay : v;
    endfunction

endpackage

// File: rtl/reaction_round_ctrl_tick_counter.sv
// 9-bit loadable up/down counter advanced by a tick enable, with a terminal-count flag.
module tick_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [8:0] i_load_val,
    input  logic       i_en,
    input  logic       i_up,
    input  logic [8:0] i_tc_val,
    output logic [8:0] o_count,
    output logic       o_tc
);

    logic [8:0] r_count;

    // NOTE: non-blocking assignments make every flop sample pre-edge values, so the
    // counters and the FSM that reads them advance together without race.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= i_up ? r_count + 9'd1 : r_count - 9'd1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == i_tc_val);

endmodule

// File: rtl/reaction_round_ctrl.sv
// Multi-round reaction game sequencer: random delay, go window, scoring and round
// bookkeeping, driven by a 100 Hz tick enable.
module reaction_round_ctrl
    import reaction_round_ctrl_pkg::*;
#(
    parameter int ROUNDS     = 5,
    parameter int MIN_DELAY  = 100,
    parameter int TIMEOUT    = 300,
    parameter int HOLD_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic       abort,
    input  logic       press,
    input  logic [8:0] rand_val,
    output logic       lfsr_load,
    output logic [2:0] phase,
    output logic       go,
    output logic [2:0] round_idx,
    output logic [1:0] result,
    output logic [8:0] reaction_time,
    output logic [8:0] best_time,
    output logic [2:0] hits,
    output logic       done
);

    localparam logic [8:0] MIN9       = 9'(MIN_DELAY);
    localparam logic [8:0] RX_LAST    = 9'(TIMEOUT - 1);
    localparam logic [8:0] HOLD9      = 9'(HOLD_TICKS);
    localparam logic [2:0] ROUND_LAST = 3'(ROUNDS - 1);

    phase_e     r_state, w_next;
    logic       w_dly_load, w_dly_en, w_rx_load, w_rx_en;
    logic [8:0] w_dly_val, w_dly_cnt, w_rx_cnt;
    logic       w_dly_tc, w_rx_tc, w_dly_exp;
    logic       w_start_acc, w_hit, w_early, w_miss, w_hold_done, w_last;

    logic       r_lfsr_load, r_done;
    logic [2:0] r_round, r_hits;
    result_e    r_result;
    logic [8:0] r_react, r_best;

    // Delay counter serves both the pre-go wait and the result hold.
    tick_counter u_delay (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_dly_load),
        .i_load_val (w_dly_val),
        .i_en       (w_dly_en),
        .i_up       (1'b0),
        .i_tc_val   (9'd1),
        .o_count    (w_dly_cnt),
        .o_tc       (w_dly_tc)
    );

    tick_counter u_react (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_rx_load),
        .i_load_val (9'd0),
        .i_en       (w_rx_en),
        .i_up       (1'b1),
        .i_tc_val   (RX_LAST),
        .o_count    (w_rx_cnt),
        .o_tc       (w_rx_tc)
    );

    // A zero count (HOLD_TICKS of 0) expires on the first tick instead of wrapping.
    assign w_dly_exp = w_dly_tc || (w_dly_cnt == '0);
    assign w_last    = (r_round == ROUND_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= PH_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        w_next      = r_state;
        w_dly_load  = 1'b0;
        w_dly_val   = arm_delay(rand_val, MIN9);
        w_dly_en    = 1'b0;
        w_rx_load   = 1'b0;
        w_rx_en     = 1'b0;
        w_start_acc = 1'b0;
        w_hit       = 1'b0;
        w_early     = 1'b0;
        w_miss      = 1'b0;
        w_hold_done = 1'b0;
        case (r_state)
            PH_IDLE, PH_FINISH: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_next      = PH_ARM;
                end
            end
            PH_ARM: begin
                w_dly_load = 1'b1;
                w_next     = PH_WAIT;
            end
            PH_WAIT: begin
                if (press) begin
                    w_early = 1'b1;
                    w_next  = PH_RESULT;
                end else if (tick) begin
                    w_dly_en = 1'b1;
                    if (w_dly_exp) begin
                        w_rx_load = 1'b1;
                        w_next    = PH_GO;
                    end
                end
            end
            PH_GO: begin
                if (press) begin
                    w_hit  = 1'b1;
                    w_next = PH_RESULT;
                end else if (tick) begin
                    if (w_rx_tc) begin
                        w_miss = 1'b1;
                        w_next = PH_RESULT;
                    end else begin
                        w_rx_en = 1'b1;
                    end
                end
            end
            PH_RESULT: begin
                if (tick) begin
                    w_dly_en = 1'b1;
                    if (w_dly_exp) begin
                        w_hold_done = 1'b1;
                        w_next      = w_last ? PH_FINISH : PH_ARM;
                    end
                end
            end
            default: w_next = PH_IDLE;
        endcase
        if (w_hit || w_early || w_miss) begin
            w_dly_load = 1'b1;
            w_dly_val  = HOLD9;
        end
        // abort beats every event: no score, done or reseed side effects survive it.
        if (abort) begin
            w_next      = PH_IDLE;
            w_start_acc = 1'b0;
            w_hit       = 1'b0;
            w_early     = 1'b0;
            w_miss      = 1'b0;
            w_hold_done = 1'b0;
        end
    end

    always_comb begin
        phase = r_state;
        go    = (r_state == PH_GO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr_load <= 1'b0;
            r_done      <= 1'b0;
            r_round     <= '0;
            r_hits      <= '0;
            r_result    <= RES_NONE;
            r_react     <= '0;
            r_best      <= BEST_NONE;
        end else begin
            r_lfsr_load <= w_start_acc;
            r_done      <= w_hold_done && w_last;
            if (w_start_acc) begin
                r_round  <= '0;
                r_hits   <= '0;
                r_result <= RES_NONE;
                r_best   <= BEST_NONE;
            end
            if (w_hit) begin
                r_result <= RES_HIT;
                r_react  <= w_rx_cnt;
                r_hits   <= r_hits + 3'd1;
                if (w_rx_cnt < r_best) r_best <= w_rx_cnt;
            end
            if (w_early) r_result <= RES_EARLY;
            if (w_miss)  r_result <= RES_MISS;
            if (w_hold_done && !w_last) r_round <= r_round + 3'd1;
        end
    end

    assign lfsr_load     = r_lfsr_load;
    assign done          = r_done;
    assign round_idx     = r_round;
    assign hits          = r_hits;
    assign result        = r_result;
    assign reaction_time = r_react;
    assign best_time     = r_best;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Self-checking bench for reaction_round_ctrl: table-driven games, model-checked random
// games and hand-written abort/reset/coincidence sequences.
module tb_reaction_round_ctrl;

    localparam int MIN_DELAY  = 100;
    localparam int TIMEOUT    = 300;
    localparam int HOLD_TICKS = 100;

    localparam logic [2:0] PH_IDLE = 3'd0, PH_ARM = 3'd1, PH_WAIT = 3'd2,
                           PH_GO = 3'd3, PH_RESULT = 3'd4, PH_FINISH = 3'd5;
    localparam logic [1:0] R_NONE = 2'd0, R_HIT = 2'd1, R_EARLY = 2'd2, R_MISS = 2'd3;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       tick = 1'b0, start = 1'b0, abort = 1'b0, press = 1'b0;
    logic [8:0] rand_val = '0;

    logic       lfsr_load, go, done;
    logic [2:0] phase, round_idx, hits;
    logic [1:0] result;
    logic [8:0] reaction_time, best_time;

    logic       r1_lfsr_load, r1_go, r1_done;
    logic [2:0] r1_phase, r1_round_idx, r1_hits;
    logic [1:0] r1_result;
    logic [8:0] r1_react, r1_best;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reaction_round_ctrl #(.ROUNDS(3), .MIN_DELAY(MIN_DELAY), .TIMEOUT(TIMEOUT),
                          .HOLD_TICKS(HOLD_TICKS)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .abort(abort),
        .press(press), .rand_val(rand_val), .lfsr_load(lfsr_load), .phase(phase),
        .go(go), .round_idx(round_idx), .result(result), .reaction_time(reaction_time),
        .best_time(best_time), .hits(hits), .done(done)
    );

    reaction_round_ctrl #(.ROUNDS(1), .MIN_DELAY(MIN_DELAY), .TIMEOUT(TIMEOUT),
                          .HOLD_TICKS(HOLD_TICKS)) dut1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .abort(abort),
        .press(press), .rand_val(rand_val), .lfsr_load(r1_lfsr_load), .phase(r1_phase),
        .go(r1_go), .round_idx(r1_round_idx), .result(r1_result), .reaction_time(r1_react),
        .best_time(r1_best), .hits(r1_hits), .done(r1_done)
    );

    typedef struct {
        logic [8:0] rv;
        bit         do_press;
        int         pn;       // ticks elapsed in the round before the press cycle
        bit         pc;       // press shares its cycle with a tick
        logic [1:0] e_res;
        logic [8:0] e_react;
        logic [2:0] e_hits;
        logic [8:0] e_best;
    } row_t;

    row_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic t, input logic p, input logic s, input logic a);
        tick = t; press = p; start = s; abort = a;
        @(posedge clk);
        #1;
        tick = 1'b0; press = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    function automatic int delay_of(input int rv);
        int v;
        v = (rv < MIN_DELAY) ? rv + MIN_DELAY : rv;
        return (v == 0) ? MIN_DELAY : v;
    endfunction

    task automatic play_round(input row_t r, input bit new_game, input bit last_round,
                              input logic [2:0] rnd);
        int d, ticks, errs, k;
        bit ended, t, p, eg;
        rand_val = r.rv;
        d = delay_of(int'(r.rv));
        if (new_game) begin
            cyc(0, 0, 1, 0);
            check("lfsr_load_on_start", lfsr_load, 1);
            check("arm_after_start", phase, PH_ARM);
            check("result_cleared", result, R_NONE);
            check("hits_cleared", hits, 0);
            check("best_cleared", best_time, 9'h1FF);
        end
        cyc(0, 0, 0, 0);
        check("wait_after_arm", phase, PH_WAIT);
        check("lfsr_load_one_clk", lfsr_load, 0);
        check("round_idx", round_idx, rnd);
        ticks = 0; ended = 1'b0; errs = 0; k = 0;
        while (!ended) begin
            for (int h = 0; h < 2; h++) begin
                if (!ended) begin
                    t = (h == 1);
                    p = r.do_press && (k == r.pn) && (h == int'(r.pc));
                    cyc(t, p, 0, 0);
                    if (t) ticks++;
                    if (p) ended = 1'b1;
                    else if (ticks >= d + TIMEOUT) ended = 1'b1;
                    if (!ended) begin
                        eg = (ticks >= d);
                        if (go !== eg) errs++;
                        if (phase !== (eg ? PH_GO : PH_WAIT)) errs++;
                    end
                end
            end
            k++;
        end
        check("go_profile", errs, 0);
        check("phase_result", phase, PH_RESULT);
        check("go_low_in_result", go, 0);
        check("result", result, r.e_res);
        check("reaction_time", reaction_time, r.e_react);
        check("hits", hits, r.e_hits);
        check("best_time", best_time, r.e_best);
        errs = 0;
        for (int j = 0; j < HOLD_TICKS; j++) begin
            cyc(0, 1'($urandom_range(0, 1)), 0, 0);
            if (phase !== PH_RESULT || done !== 1'b0) errs++;
            cyc(1, 0, 0, 0);
            if (j < HOLD_TICKS - 1 && (phase !== PH_RESULT || done !== 1'b0)) errs++;
        end
        check("hold_profile", errs, 0);
        check("result_after_hold", result, r.e_res);
        check("hits_after_hold", hits, r.e_hits);
        if (new_game) begin
            check("r1_finish", r1_phase, PH_FINISH);
            check("r1_done", r1_done, 1);
            check("r1_result", r1_result, r.e_res);
            check("r1_hits", r1_hits, r.e_hits);
            check("r1_best", r1_best, r.e_best);
            if (r.e_res == R_HIT) check("r1_react", r1_react, r.e_react);
        end
        if (last_round) begin
            check("phase_finish", phase, PH_FINISH);
            check("done_pulse", done, 1);
            check("final_round_idx", round_idx, rnd);
            cyc(0, 1, 0, 0);
            check("done_one_clk", done, 0);
            check("finish_holds", phase, PH_FINISH);
            check("finish_hits_held", hits, r.e_hits);
        end else begin
            check("next_arm", phase, PH_ARM);
            check("round_advance", round_idx, rnd + 3'd1);
            check("no_done_midgame", done, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary, expected completion");
        $fatal(1);
    end

    initial begin
        row_t rw;
        int d, sc, errs;
        logic [8:0] m_react, m_best;
        logic [2:0] m_hits;

        //          rv      prs   pn   pc   result   react  hits  best
        tbl[0] = '{9'd40,  1'b1, 190, 1'b0, R_HIT,   9'd50,  3'd1, 9'd50};
        tbl[1] = '{9'd200, 1'b1, 230, 1'b1, R_HIT,   9'd30,  3'd2, 9'd30};
        tbl[2] = '{9'd0,   1'b0, 0,   1'b0, R_MISS,  9'd30,  3'd2, 9'd30};
        tbl[3] = '{9'd40,  1'b1, 165, 1'b0, R_HIT,   9'd25,  3'd1, 9'd25};
        tbl[4] = '{9'd300, 1'b1, 10,  1'b0, R_EARLY, 9'd25,  3'd1, 9'd25};
        tbl[5] = '{9'd99,  1'b1, 198, 1'b1, R_EARLY, 9'd25,  3'd1, 9'd25};
        tbl[6] = '{9'd150, 1'b1, 157, 1'b1, R_HIT,   9'd7,   3'd1, 9'd7};
        tbl[7] = '{9'd100, 1'b1, 399, 1'b1, R_HIT,   9'd299, 3'd2, 9'd7};
        tbl[8] = '{9'd60,  1'b1, 165, 1'b0, R_HIT,   9'd5,   3'd3, 9'd5};

        repeat (3) @(posedge clk);
        #1;
        check("rst_phase", phase, PH_IDLE);
        check("rst_go", go, 0);
        check("rst_round", round_idx, 0);
        check("rst_result", result, R_NONE);
        check("rst_react", reaction_time, 0);
        check("rst_best", best_time, 9'h1FF);
        check("rst_hits", hits, 0);
        check("rst_done", done, 0);
        check("rst_lfsr_load", lfsr_load, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_release", phase, PH_IDLE);

        cyc(0, 0, 1, 1);
        check("abort_beats_start_phase", phase, PH_IDLE);
        check("abort_beats_start_load", lfsr_load, 0);

        for (int i = 0; i < 9; i++)
            play_round(tbl[i], (i % 3) == 0, (i % 3) == 2, 3'(i % 3));

        m_react = tbl[8].e_react;
        for (int g = 0; g < 3; g++) begin
            m_hits = '0;
            m_best = 9'h1FF;
            for (int rr = 0; rr < 3; rr++) begin
                rw.rv = 9'($urandom_range(0, 511));
                d = delay_of(int'(rw.rv));
                sc = $urandom_range(0, 2);
                rw.pc = 1'($urandom_range(0, 1));
                rw.do_press = (sc != 2);
                rw.pn = (sc == 0) ? $urandom_range(0, d - 1) : d + $urandom_range(0, TIMEOUT - 1);
                if (rw.do_press && rw.pn < d) begin
                    rw.e_res = R_EARLY;
                end else if (rw.do_press && rw.pn < d + TIMEOUT) begin
                    rw.e_res = R_HIT;
                    m_react = 9'(rw.pn - d);
                    m_hits = m_hits + 3'd1;
                    if (m_react < m_best) m_best = m_react;
                end else begin
                    rw.e_res = R_MISS;
                end
                rw.e_react = m_react;
                rw.e_hits = m_hits;
                rw.e_best = m_best;
                play_round(rw, rr == 0, rr == 2, 3'(rr));
            end
        end

        // start while waiting must be ignored; abort then returns to IDLE
        rand_val = 9'd200;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        repeat (5) begin
            cyc(0, 0, 0, 0);
            cyc(1, 0, 0, 0);
        end
        cyc(1, 0, 1, 0);
        check("start_in_wait_no_load", lfsr_load, 0);
        check("start_in_wait_phase", phase, PH_WAIT);
        check("start_in_wait_go", go, 0);
        cyc(0, 0, 0, 1);
        check("abort_in_wait", phase, PH_IDLE);

        // abort during RESULT: IDLE, scores retained, no done pulse ever
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        check("early_result", result, R_EARLY);
        check("r1_early_result", r1_result, R_EARLY);
        repeat (3) begin
            cyc(0, 0, 0, 0);
            cyc(1, 0, 0, 0);
        end
        cyc(1, 0, 0, 1);
        check("abort_in_result_phase", phase, PH_IDLE);
        check("r1_abort_in_result_phase", r1_phase, PH_IDLE);
        check("abort_keeps_result", result, R_EARLY);
        check("abort_no_done", done, 0);
        errs = 0;
        for (int j = 0; j < 2 * HOLD_TICKS + 10; j++) begin
            cyc(1'(j % 2), 0, 0, 0);
            if (done !== 1'b0 || r1_done !== 1'b0 || phase !== PH_IDLE) errs++;
        end
        check("no_done_after_abort", errs, 0);

        // reset mid-GO: everything back to reset values without waiting for a clock
        rand_val = 9'd0;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        for (int j = 0; j < MIN_DELAY; j++) begin
            cyc(0, 0, 0, 0);
            cyc(1, 0, 0, 0);
        end
        check("go_before_reset", go, 1);
        check("phase_go_before_reset", phase, PH_GO);
        cyc(1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_phase", phase, PH_IDLE);
        check("async_rst_go", go, 0);
        check("async_rst_result", result, R_NONE);
        check("async_rst_react", reaction_time, 0);
        check("async_rst_best", best_time, 9'h1FF);
        check("async_rst_hits", hits, 0);
        check("async_rst_round", round_idx, 0);
        check("async_rst_done", done, 0);
        check("async_rst_load", lfsr_load, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_midgame_reset", phase, PH_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
